// File: rtl/gray_monitor.sv
// Self-checking tail of the gray counter stage: tracks gray steps, counts laps and flags faults.
// Latency 1 cycle from sampling edge to Bin/Step/Laps; no backpressure, En gates every sample.
module gray_monitor #(
    parameter int WIDTH = 3,
    parameter int LAP_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             OverflowIn,
    output logic [WIDTH-1:0] Bin,
    output logic             Step,
    output logic [LAP_W-1:0] Laps,
    output logic             Error,
    output logic [1:0]       ErrCode
);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

    localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LAP_W-1:0] LAPS_MAX = {LAP_W{1'b1}};
    localparam logic [LAP_W-1:0] LAPS_ONE = {{(LAP_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       EC_ILLEGAL = 2'b01;
    localparam logic [1:0]       EC_OVF     = 2'b10;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [WIDTH-1:0] r_bin, w_bin_nxt;
    logic             r_step, w_step_nxt;
    logic [LAP_W-1:0] r_laps, w_laps_nxt;
    logic             r_err, w_err_nxt;
    logic [1:0]       r_code, w_code_nxt;
    logic             r_ovf_prev, w_ovf_nxt;

    logic [WIDTH-1:0] w_p, w_n;
    logic             w_hold, w_plus, w_wrap, w_rise;

    assign w_p    = gray2bin(r_prev);
    assign w_n    = gray2bin(GrayIn);
    assign w_hold = (GrayIn == r_prev);
    assign w_plus = (w_p != BIN_MAX) && (w_n == w_p + BIN_ONE);
    assign w_wrap = (w_p == BIN_MAX) && (w_n == '0);
    // Sticky upstream flag: only its 0->1 edge is meaningful, and only on a wrap.
    assign w_rise = OverflowIn && !r_ovf_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_bin_nxt   = r_bin;
        w_step_nxt  = 1'b0;
        w_laps_nxt  = r_laps;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        w_ovf_nxt   = r_ovf_prev;
        if (En) begin
            w_ovf_nxt = OverflowIn;
            case (r_state)
                S_IDLE: begin
                    w_prev_nxt  = GrayIn;
                    w_bin_nxt   = w_n;
                    w_state_nxt = S_TRACK;
                end
                S_TRACK: begin
                    if (!(w_hold || w_plus || w_wrap)) begin
                        w_state_nxt = S_FAULT;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = EC_ILLEGAL;
                    end else if (w_wrap) begin
                        if (OverflowIn) begin
                            w_prev_nxt = GrayIn;
                            w_bin_nxt  = w_n;
                            w_step_nxt = 1'b1;
                            if (r_laps != LAPS_MAX) begin
                                w_laps_nxt = r_laps + LAPS_ONE;
                            end
                        end else begin
                            w_state_nxt = S_FAULT;
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = EC_OVF;
                        end
                    end else if (w_rise) begin
                        w_state_nxt = S_FAULT;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = EC_OVF;
                    end else if (w_plus) begin
                        w_prev_nxt = GrayIn;
                        w_bin_nxt  = w_n;
                        w_step_nxt = 1'b1;
                    end
                end
                S_FAULT: begin
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_bin      <= '0;
            r_step     <= 1'b0;
            r_laps     <= '0;
            r_err      <= 1'b0;
            r_code     <= 2'b00;
            r_ovf_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_bin      <= w_bin_nxt;
            r_step     <= w_step_nxt;
            r_laps     <= w_laps_nxt;
            r_err      <= w_err_nxt;
            r_code     <= w_code_nxt;
            r_ovf_prev <= w_ovf_nxt;
        end
    end

    assign Bin     = r_bin;
    assign Step    = r_step;
    assign Laps    = r_laps;
    assign Error   = r_err;
    assign ErrCode = r_code;

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: counter-driven and random stimulus against a value-level reference model.
module tb_gray_monitor;

    localparam int W  = 3;
    localparam int LW = 4;

    logic          Clk = 1'b0;
    logic          Reset, En, OverflowIn;
    logic [W-1:0]  GrayIn;
    logic [W-1:0]  Bin;
    logic          Step;
    logic [LW-1:0] Laps;
    logic          Error;
    logic [1:0]    ErrCode;

    always #5 Clk = ~Clk;

    gray_monitor #(.WIDTH(W), .LAP_W(LW)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
        .Bin(Bin), .Step(Step), .Laps(Laps), .Error(Error), .ErrCode(ErrCode)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: values only; mode 0 = waiting for first sample, 1 = tracking, 2 = faulted.
    int m_mode, m_prev_val, m_bin, m_step, m_laps, m_err, m_code, m_ovf_seen;

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input int g);
        for (int v = 0; v < (1 << W); v++) if (to_gray(v) == g) return v;
        return -1;
    endfunction

    task automatic model_fault(input int code);
        m_mode = 2;
        m_err  = 1;
        m_code = code;
    endtask

    task automatic model_update();
        int n;
        n = from_gray(int'(GrayIn));
        if (Reset) begin
            m_mode = 0; m_prev_val = 0; m_bin = 0; m_step = 0;
            m_laps = 0; m_err = 0; m_code = 0; m_ovf_seen = 0;
        end else if (!En) begin
            m_step = 0;
        end else begin
            m_step = 0;
            if (m_mode == 0) begin
                m_prev_val = n; m_bin = n; m_mode = 1;
            end else if (m_mode == 1) begin
                if (n == m_prev_val) begin
                    if (OverflowIn && !m_ovf_seen) model_fault(2);
                end else if (m_prev_val == (1 << W) - 1 && n == 0) begin
                    if (OverflowIn) begin
                        m_prev_val = 0; m_bin = 0; m_step = 1;
                        m_laps = (m_laps + 1 > (1 << LW) - 1) ? (1 << LW) - 1 : m_laps + 1;
                    end else model_fault(2);
                end else if (n == m_prev_val + 1) begin
                    if (OverflowIn && !m_ovf_seen) model_fault(2);
                    else begin m_prev_val = n; m_bin = n; m_step = 1; end
                end else begin
                    model_fault(1);
                end
            end
            m_ovf_seen = OverflowIn;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        #1;
        chk("bin",  Bin,     m_bin);
        chk("step", Step,    m_step);
        chk("laps", Laps,    m_laps);
        chk("err",  Error,   m_err);
        chk("code", ErrCode, m_code);
    endtask

    // Upstream counter stand-in.
    int cnt;
    bit ovs;

    task automatic cstep();
        if (cnt == (1 << W) - 1) begin cnt = 0; ovs = 1'b1; end
        else cnt++;
        GrayIn     = W'(to_gray(cnt));
        OverflowIn = ovs;
    endtask

    task automatic do_reset(input int cyc);
        Reset = 1'b1; En = 1'b0; cnt = 0; ovs = 1'b0;
        GrayIn = '0; OverflowIn = 1'b0;
        repeat (cyc) tick();
        Reset = 1'b0;
    endtask

    task automatic start();
        do_reset(2);
        En = 1'b1;
        tick();
    endtask

    task automatic run(input int n, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < stall_pct) begin
                En = 1'($urandom_range(1));
                tick();
            end
            En = 1'b1;
            cstep();
            tick();
        end
    endtask

    initial begin
        int keep_bin;
        Reset = 1'b1; En = 1'b0; GrayIn = '0; OverflowIn = 1'b0;
        cnt = 0; ovs = 1'b0;
        m_mode = 0; m_prev_val = 0; m_bin = 0; m_step = 0;
        m_laps = 0; m_err = 0; m_code = 0; m_ovf_seen = 0;

        // Reset state and free-running count.
        do_reset(2);
        chk("rst_bin", Bin, 0);
        chk("rst_err", Error, 0);
        En = 1'b1;
        tick();
        run(7, 0);
        chk("run_bin7", Bin, 7);
        chk("run_step", Step, 1);

        // Three laps in total, with random stalls.
        run(17, 20);
        chk("laps3", Laps, 3);
        chk("laps3_err", Error, 0);

        // En low freezes everything but Step.
        run(3, 0);
        keep_bin = int'(Bin);
        En = 1'b0;
        repeat (5) tick();
        chk("frz_bin", Bin, keep_bin);
        chk("frz_step", Step, 0);
        chk("frz_laps", Laps, 3);
        run(3, 0);
        chk("resume_err", Error, 0);

        // Skip 1 -> 3 is illegal.
        start();
        run(1, 0);
        GrayIn = 3'b010;
        tick();
        chk("skip_err", Error, 1);
        chk("skip_code", ErrCode, 1);
        chk("skip_bin", Bin, 1);
        GrayIn = 3'b011;
        repeat (2) tick();
        chk("skip_sticky", ErrCode, 1);

        // Wrap without overflow.
        start();
        run(7, 0);
        GrayIn = 3'b000; OverflowIn = 1'b0;
        tick();
        chk("wrap_err", Error, 1);
        chk("wrap_code", ErrCode, 2);
        chk("wrap_laps", Laps, 0);

        // Reset out of fault, then saturate the lap counter.
        do_reset(1);
        chk("clr_err", Error, 0);
        chk("clr_code", ErrCode, 0);
        chk("clr_bin", Bin, 0);
        En = 1'b1;
        tick();
        run(17 * 8, 10);
        chk("sat_laps", Laps, 15);
        chk("sat_err", Error, 0);

        // Random mix: counting, stalls, stray codes and overflow glitches, occasional resets.
        start();
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(99);
            if ((m_mode == 2 && r < 10) || r == 0) begin
                do_reset(1);
                continue;
            end
            En = ($urandom_range(9) != 0);
            if (r < 4) begin
                GrayIn     = W'($urandom_range((1 << W) - 1));
                cnt        = from_gray(int'(GrayIn));
                ovs        = 1'($urandom_range(1));
                OverflowIn = ovs;
            end else if (r < 75) begin
                if (En) cstep();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
